fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Owns the single-port frame-buffer SRAM and the double-buffer swap. Arbitrates
//  between display readout (rd_*) and drawing-engine pixel writes (draw_*), and
//  issues wr_en to the drawing engine as its per-pixel advance strobe.
//  Swaps front/back buffer only on a frame-clock rising edge after a completed
//  frame, so a partially drawn frame is never displayed.
// PARAMETERS
//  FB_W    320  frame-buffer width in pixels (must be 320; address uses y*256+y*64)
//  FB_H    240  frame-buffer height in pixels
//  ADDR_W  18   SRAM word address width (2*FB_W*FB_H = 153600 < 2^18)
//  DATA_W  8    pixel colour width
// PORTS
//  Clk            in   1       system clock
//  Reset          in   1       synchronous, active-high
//  frame_clk_edge in   2       {prev,cur} frame clock sample; 2'b01 = frame start
//  draw_req       in   1       drawing engine holds valid draw_x/draw_y/draw_color
//  draw_x         in   10      pixel column
//  draw_y         in   10      pixel row
//  draw_color     in   DATA_W  pixel colour
//  draw_done      in   1       drawing engine finished current frame (level)
//  wr_en          out  1       write grant; engine advances to next pixel on it
//  rd_req         in   1       display readout request (one pixel)
//  rd_x, rd_y     in   10 each readout pixel coordinates
//  rd_valid       out  1       rd_data valid
//  rd_data        out  DATA_W  readout pixel
//  sram_addr      out  ADDR_W  SRAM address (registered)
//  sram_we        out  1       SRAM write strobe (registered)
//  sram_wdata     out  DATA_W  SRAM write data (registered)
//  sram_rdata     in   DATA_W  SRAM read data, valid 1 cycle after address
//  buffer_using   out  1       front (displayed) buffer index; draws go to ~buffer_using
//  swap_skipped   out  1       1-cycle pulse: frame edge hit while frame unfinished
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, buffer_using=0. Reset mid-frame aborts draw.
//  - addr = buf*FB_W*FB_H + (y<<8) + (y<<6) + x, computed in ADDR_W bits.
//    Reads use buf=buffer_using; writes use buf=~buffer_using.
//  - FSM: IDLE -> DRAW on frame_clk_edge==2'b01 (no swap).
//    DRAW -> DONE when draw_done=1. DONE -> DRAW on edge, toggling buffer_using.
//    DRAW + edge with draw_done=0: stay DRAW, no swap, swap_skipped=1 for 1 cycle.
//    DRAW + edge + draw_done=1 in the same cycle: treated as done; swap, stay DRAW.
//  - Arbitration per cycle, read has absolute priority:
//    rd_req=1: read granted; sram_addr<=read addr, sram_we<=0; rd_valid=1 and
//    rd_data=sram_rdata two cycles after rd_req (addr reg + SRAM latency).
//    rd_req=0, state DRAW, draw_req=1: wr_en=1 (combinational, same cycle);
//    next cycle sram_addr/sram_wdata/sram_we=1 with the granted pixel.
//    Otherwise wr_en=0, sram_we<=0.
//  - wr_en never asserted in IDLE or DONE; draw_req held there is stalled.
//  - Clipping: pixel with x>=FB_W or y>=FB_H gets wr_en=1 (consumed) but sram_we=0.
//  - Read coords out of range: rd_valid still pulses, rd_data forced to 0.
//  - Back-to-back grants: one SRAM access per cycle, no bubbles.
// TESTING
//  1 Reset, edge 01, draw_req=1 (x=80,y=1,c=3F) -> wr_en same cycle; next cycle
//    sram_we=1, sram_addr=76800+320+80=77200, wdata=3F.
//  2 rd_req and draw_req both high 3 cycles -> wr_en=0 all 3; rd_valid 3 cycles
//    starting 2 cycles later; write granted on first cycle rd_req drops.
//  3 draw_done=1 then edge -> buffer_using 0->1; next write at y=0,x=0 -> addr 0.
//  4 edge while DRAW and draw_done=0 -> swap_skipped 1-cycle pulse, buffer_using held.
//  5 draw_x=330 -> wr_en=1, sram_we=0; rd at (400,10) -> rd_valid=1, rd_data=0.
//  6 Reset asserted during DRAW with draw_req=1 -> wr_en=0 next cycle, IDLE,
//    buffer_using=0; no writes until next edge 01.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// ----------------------------------------------------------------------------
// fb_port_arbiter
//   Owns the single-port frame-buffer SRAM and the front/back buffer swap.
//   Display readout and drawing-engine pixel writes share the SRAM port, one
//   access per cycle. Reads always win. A write grant is signalled back to the
//   drawing engine on wr_en in the same cycle, and the engine uses it as its
//   per-pixel advance strobe. The displayed (front) buffer only flips on a
//   frame-clock rising edge after the drawing engine has finished the frame,
//   so a partially drawn frame is never shown.
//
// Ports
//   Clk, Reset        system clock, synchronous active-high reset
//   frame_clk_edge    {prev,cur} frame clock sample, 2'b01 marks a frame start
//   draw_req          engine presents draw_x/draw_y/draw_color
//   draw_done         engine has finished the current frame (level)
//   wr_en             combinational write grant / pixel advance strobe
//   rd_req,rd_x,rd_y  single-pixel readout request
//   rd_valid,rd_data  readout result, two cycles after rd_req
//   sram_*            registered SRAM address/strobe/data, sram_rdata is
//                     valid one cycle after sram_addr
//   buffer_using      front buffer index; draws go to the other buffer
//   swap_skipped      one-cycle pulse, the cycle after a frame edge arrived
//                     while the frame was still being drawn
// ----------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        frame_clk_edge,
  input  logic              draw_req,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [DATA_W-1:0] draw_color,
  input  logic              draw_done,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic [9:0]        rd_x,
  input  logic [9:0]        rd_y,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              buffer_using,
  output logic              swap_skipped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(FB_W * FB_H);
  localparam logic [9:0]        FB_W_C      = 10'(FB_W);
  localparam logic [9:0]        FB_H_C      = 10'(FB_H);

  state_t              state_q, state_d;
  logic                buffer_q, buffer_d;
  logic                skip_q, skip_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rdStage1_q, rdStage1_d;
  logic                rdOor1_q, rdOor1_d;
  logic                rdValid_q;
  logic                rdOor2_q;

  logic                frameStart;
  logic                writeGrant;
  logic                drawInRange;
  logic                readInRange;

  // Buffer base plus y*320 written as (y<<8)+(y<<6), which keeps the row
  // offset multiplier-free; only valid because FB_W is fixed at 320.
  function automatic logic [ADDR_W-1:0] pixelAddr(input logic bufSel,
                                                  input logic [9:0] x,
                                                  input logic [9:0] y);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] yExt;
    logic [ADDR_W-1:0] xExt;
    base = bufSel ? FRAME_WORDS : '0;
    yExt = ADDR_W'(y);
    xExt = ADDR_W'(x);
    return base + (yExt << 8) + (yExt << 6) + xExt;
  endfunction

  assign frameStart  = (frame_clk_edge == 2'b01);
  assign drawInRange = (draw_x < FB_W_C) && (draw_y < FB_H_C);
  assign readInRange = (rd_x < FB_W_C) && (rd_y < FB_H_C);

  // Write grant is only possible while actively drawing and when the display
  // is not using the port this cycle. It is forced low during Reset so the
  // engine never advances on a pixel that the reset is about to discard.
  assign writeGrant = !Reset && !rd_req && (state_q == DRAW) && draw_req;
  assign wr_en      = writeGrant;

  // Frame sequencing. A frame edge flips the buffers only when the frame is
  // known complete, either already latched in DONE or signalled by draw_done
  // in the very same cycle as the edge.
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    skip_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frameStart) begin
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (frameStart) begin
          if (draw_done) begin
            buffer_d = ~buffer_q;
          end else begin
            skip_d = 1'b1;
          end
        end else if (draw_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (frameStart) begin
          state_d  = DRAW;
          buffer_d = ~buffer_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Port arbitration. A clipped pixel is still granted so the engine moves
  // on, but it never reaches the SRAM. The address register holds its value
  // on idle cycles to avoid needless toggling on the SRAM bus.
  always_comb begin
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    rdStage1_d = rd_req;
    rdOor1_d   = !readInRange;
    if (rd_req) begin
      addr_d = pixelAddr(buffer_q, rd_x, rd_y);
    end else if (writeGrant && drawInRange) begin
      addr_d  = pixelAddr(~buffer_q, draw_x, draw_y);
      wdata_d = draw_color;
      we_d    = 1'b1;
    end
  end

  // All state registers. The read tracker is two stages deep: one for the
  // address register and one for the SRAM's own read latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      buffer_q   <= 1'b0;
      skip_q     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdStage1_q <= 1'b0;
      rdOor1_q   <= 1'b0;
      rdValid_q  <= 1'b0;
      rdOor2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      buffer_q   <= buffer_d;
      skip_q     <= skip_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdStage1_q <= rdStage1_d;
      rdOor1_q   <= rdOor1_d;
      rdValid_q  <= rdStage1_q;
      rdOor2_q   <= rdOor1_q;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_we      = we_q;
  assign sram_wdata   = wdata_q;
  assign buffer_using = buffer_q;
  assign swap_skipped = skip_q;
  assign rd_valid     = rdValid_q;
  // Out-of-range reads still return a beat, but with a zero pixel rather
  // than whatever the wrapped address happened to hold.
  assign rd_data      = (rdValid_q && !rdOor2_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fb_port_arbiter
//   Self-checking bench for fb_port_arbiter. Contains a behavioural SRAM, a
//   frame-level reference model with a shadow image of both buffers, a
//   per-cycle compare process and directed scenarios with literal values.
// ----------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int AW    = 18;
  localparam int DW    = 8;
  localparam int FRAME = FB_W * FB_H;
  localparam int MEMSZ = 1 << AW;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [1:0]    frame_clk_edge = 2'b00;
  logic          draw_req = 1'b0;
  logic [9:0]    draw_x = '0;
  logic [9:0]    draw_y = '0;
  logic [DW-1:0] draw_color = '0;
  logic          draw_done = 1'b0;
  logic          wr_en;
  logic          rd_req = 1'b0;
  logic [9:0]    rd_x = '0;
  logic [9:0]    rd_y = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          buffer_using;
  logic          swap_skipped;

  int checks = 0;
  int failures = 0;

  fb_port_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk_edge(frame_clk_edge),
    .draw_req(draw_req),
    .draw_x(draw_x),
    .draw_y(draw_y),
    .draw_color(draw_color),
    .draw_done(draw_done),
    .wr_en(wr_en),
    .rd_req(rd_req),
    .rd_x(rd_x),
    .rd_y(rd_y),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .sram_addr(sram_addr),
    .sram_we(sram_we),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .buffer_using(buffer_using),
    .swap_skipped(swap_skipped)
  );

  always #5 Clk = ~Clk;

  // Behavioural SRAM with one cycle of read latency.
  logic [DW-1:0] mem [0:MEMSZ-1];
  always @(posedge Clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  // Reference model: what the frame buffer should contain and when each
  // observable event is due, expressed in pixels, frames and cycle numbers.
  typedef struct {
    int due;
    int data;
  } rdEntry_t;

  logic [DW-1:0] shadow [0:MEMSZ-1];
  rdEntry_t rdQ[$];
  bit mActive = 0;
  bit mFinished = 0;
  bit mFront = 0;
  bit mWe = 0;
  int mAddr = 0;
  int mWdata = 0;
  bit mSkip = 0;
  bit modelReady = 0;
  int cyc = 0;

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
  end

  function automatic bit inFrame(int x, int y);
    return (x < FB_W) && (y < FB_H);
  endfunction

  function automatic int pixelIndex(bit b, int x, int y);
    return (b ? FRAME : 0) + y * FB_W + x;
  endfunction

  function automatic bit expWrEn();
    return !Reset && !rd_req && mActive && !mFinished && draw_req;
  endfunction

  always @(posedge Clk) begin : model
    bit grant;
    int idx;
    grant = expWrEn();
    if (Reset) begin
      mActive = 0;
      mFinished = 0;
      mFront = 0;
      mWe = 0;
      mAddr = 0;
      mWdata = 0;
      mSkip = 0;
      rdQ.delete();
      modelReady = 1;
    end else begin
      mWe = 0;
      mSkip = 0;
      if (rd_req) begin
        rdEntry_t e;
        e.due = cyc + 2;
        e.data = inFrame(int'(rd_x), int'(rd_y)) ?
                 int'(shadow[pixelIndex(mFront, int'(rd_x), int'(rd_y))]) : 0;
        rdQ.push_back(e);
      end else if (grant && inFrame(int'(draw_x), int'(draw_y))) begin
        idx = pixelIndex(!mFront, int'(draw_x), int'(draw_y));
        shadow[idx] = draw_color;
        mWe = 1;
        mAddr = idx;
        mWdata = int'(draw_color);
      end
      if (frame_clk_edge == 2'b01) begin
        if (!mActive) mActive = 1;
        else if (mFinished || draw_done) begin
          mFront = !mFront;
          mFinished = 0;
        end else mSkip = 1;
      end else if (mActive && !mFinished && draw_done) begin
        mFinished = 1;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin : compare
    bit expValid;
    int expData;
    if (modelReady) begin
      while (rdQ.size() > 0 && rdQ[0].due < cyc) void'(rdQ.pop_front());
      expValid = (rdQ.size() > 0) && (rdQ[0].due == cyc);
      expData = expValid ? rdQ[0].data : 0;
      if (expValid) void'(rdQ.pop_front());
      checkOutput("model.wr_en", int'(wr_en), int'(expWrEn()));
      checkOutput("model.sram_we", int'(sram_we), int'(mWe));
      if (mWe) begin
        checkOutput("model.sram_addr", int'(sram_addr), mAddr);
        checkOutput("model.sram_wdata", int'(sram_wdata), mWdata);
      end
      checkOutput("model.rd_valid", int'(rd_valid), int'(expValid));
      checkOutput("model.rd_data", int'(rd_data), expData);
      checkOutput("model.buffer_using", int'(buffer_using), int'(mFront));
      checkOutput("model.swap_skipped", int'(swap_skipped), int'(mSkip));
    end
  end

  // Drives one cycle of inputs just after the clock edge, then returns just
  // after the falling edge so directed checks see settled outputs.
  task automatic applyStimulus(input bit rst, input logic [1:0] edg,
                               input bit dreq, input int dx, input int dy,
                               input int dc, input bit ddone,
                               input bit rreq, input int rx, input int ry);
    @(posedge Clk);
    #1;
    Reset = rst;
    frame_clk_edge = edg;
    draw_req = dreq;
    draw_x = 10'(dx);
    draw_y = 10'(dy);
    draw_color = 8'(dc);
    draw_done = ddone;
    rd_req = rreq;
    rd_x = 10'(rx);
    rd_y = 10'(ry);
    @(negedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset.wr_en", int'(wr_en), 0);
    checkOutput("reset.sram_we", int'(sram_we), 0);
    checkOutput("reset.sram_addr", int'(sram_addr), 0);
    checkOutput("reset.buffer_using", int'(buffer_using), 0);
    checkOutput("reset.rd_valid", int'(rd_valid), 0);

    // First frame edge, then a granted pixel into back buffer 1
    applyStimulus(0, 2'b01, 1, 80, 1, 'h3F, 0, 0, 0, 0);
    checkOutput("t1.idle_no_grant", int'(wr_en), 0);
    applyStimulus(0, 2'b00, 1, 80, 1, 'h3F, 0, 0, 0, 0);
    checkOutput("t1.wr_en", int'(wr_en), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1.sram_we", int'(sram_we), 1);
    checkOutput("t1.sram_addr", int'(sram_addr), 77200);
    checkOutput("t1.sram_wdata", int'(sram_wdata), 'h3F);

    // Read priority over a pending draw
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 2'b00, 1, 2, 3, 'h11, 0, 1, 5, 5);
      checkOutput("t2.read_blocks_write", int'(wr_en), 0);
    end
    applyStimulus(0, 2'b00, 1, 2, 3, 'h11, 0, 0, 0, 0);
    checkOutput("t2.write_after_read", int'(wr_en), 1);
    checkOutput("t2.rd_valid_mid", int'(rd_valid), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2.rd_valid_last", int'(rd_valid), 1);
    checkOutput("t2.sram_addr", int'(sram_addr), 77762);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2.rd_valid_end", int'(rd_valid), 0);

    // Completed frame then edge: buffers swap
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 2'b01, 1, 0, 0, 'h22, 1, 0, 0, 0);
    checkOutput("t3.done_stalls", int'(wr_en), 0);
    checkOutput("t3.before_swap", int'(buffer_using), 0);
    applyStimulus(0, 2'b00, 1, 0, 0, 'h22, 0, 0, 0, 0);
    checkOutput("t3.after_swap", int'(buffer_using), 1);
    checkOutput("t3.wr_en", int'(wr_en), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1, 2, 3);
    checkOutput("t3.sram_addr_zero", int'(sram_addr), 0);
    checkOutput("t3.sram_we", int'(sram_we), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1, 80, 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3.readback_a", int'(rd_data), 'h11);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3.readback_b", int'(rd_data), 'h3F);

    // Edge during an unfinished frame
    applyStimulus(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4.swap_skipped", int'(swap_skipped), 1);
    checkOutput("t4.buffer_held", int'(buffer_using), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4.pulse_ends", int'(swap_skipped), 0);

    // Clipping and boundary pixels
    applyStimulus(0, 2'b00, 1, 330, 5, 'h44, 0, 0, 0, 0);
    checkOutput("t5.clip_x_grant", int'(wr_en), 1);
    applyStimulus(0, 2'b00, 1, 319, 239, 'h55, 0, 0, 0, 0);
    checkOutput("t5.clip_x_no_we", int'(sram_we), 0);
    applyStimulus(0, 2'b00, 1, 10, 240, 'h66, 0, 0, 0, 0);
    checkOutput("t5.corner_we", int'(sram_we), 1);
    checkOutput("t5.corner_addr", int'(sram_addr), 76799);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1, 400, 10);
    checkOutput("t5.clip_y_no_we", int'(sram_we), 0);
    idle(1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5.oor_rd_valid", int'(rd_valid), 1);
    checkOutput("t5.oor_rd_data", int'(rd_data), 0);

    // Edge and draw_done together: swap and keep drawing
    applyStimulus(0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 2'b00, 1, 1, 0, 'h77, 0, 0, 0, 0);
    checkOutput("t5b.swapped", int'(buffer_using), 0);
    checkOutput("t5b.still_drawing", int'(wr_en), 1);
    applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t5b.addr", int'(sram_addr), 76801);

    // Reset in the middle of drawing
    applyStimulus(1, 2'b00, 1, 4, 4, 'h88, 0, 0, 0, 0);
    checkOutput("t6.reset_wr_en", int'(wr_en), 0);
    applyStimulus(0, 2'b00, 1, 4, 4, 'h88, 0, 0, 0, 0);
    checkOutput("t6.idle_wr_en", int'(wr_en), 0);
    checkOutput("t6.buffer", int'(buffer_using), 0);
    checkOutput("t6.no_we", int'(sram_we), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 1, 4, 4, 'h88, 0, 0, 0, 0);
    checkOutput("t6.still_stalled", int'(wr_en), 0);
    applyStimulus(0, 2'b01, 1, 4, 4, 'h88, 0, 0, 0, 0);
    applyStimulus(0, 2'b00, 1, 4, 4, 'h88, 0, 0, 0, 0);
    checkOutput("t6.resumes", int'(wr_en), 1);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 300; i++) begin
      logic [1:0] e;
      e = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'(($urandom_range(0, 2) == 0) ? 2 : 0);
      applyStimulus(($urandom_range(0, 80) == 0), e,
                    ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, 340)), int'($urandom_range(0, 250)),
                    int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0),
                    int'($urandom_range(0, 340)), int'($urandom_range(0, 250)));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
